// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions and
// the multiplier sequencer state encoding.
package cpu_defs_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] ALU_LW   = 4'b0000;
    localparam logic [3:0] ALU_SW   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_MUL  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_BGE  = 4'b1000;
    localparam logic [3:0] ALU_MULI = 4'b1001;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int RD_HI  = 27;
    localparam int RD_LO  = 23;
    localparam int IMM_HI = 17;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic logic is_mul_op(input logic [3:0] opc);
        return (opc == ALU_MUL) || (opc == ALU_MULI);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: accumulator, shifting multiplicand and
// multiplier registers, retiring BPC multiplier bits per step.
module mul_shift_add_dp #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] mcand_i,
    input  logic [XLEN-1:0] mplier_i,
    output logic [XLEN-1:0] acc_next_o,
    output logic            mplier_zero_o
);

    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_sum;
    logic [XLEN-1:0] mcand_step;
    logic [XLEN-1:0] mplier_step;

    always_comb begin
        acc_sum = acc_q;
        for (int i = 0; i < BPC; i++) begin
            if (mplier_q[i]) begin
                acc_sum = acc_sum + (mcand_q << i);
            end
        end
        mcand_step  = mcand_q << BPC;
        mplier_step = mplier_q >> BPC;
    end

    // Zero flag looks at the multiplier as it will be after this step.
    assign acc_next_o    = acc_sum;
    assign mplier_zero_o = (mplier_step == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
        end else if (step_i) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_step;
            mplier_q <= mplier_step;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// EX-stage sequencer for the shared iterative multiplier: accepts MUL/MULI,
// stalls the pipeline while the product is built, then emits a one-cycle result.
module mul_seq_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int BPC       = 1,
    parameter int EARLY_END = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [31:0]     ir_i,
    input  logic [XLEN-1:0] rs_val_i,
    input  logic [XLEN-1:0] rt_val_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      wb_rd_o,
    output mul_state_t      dbg_state_o
);

    localparam int STEPS = XLEN / BPC;
    localparam int CW    = $clog2(STEPS + 1);

    mul_state_t      state_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic [4:0]      rd_q;
    logic [3:0]      opc;
    logic            accept;
    logic            step;
    logic            run_exit;
    logic            mplier_zero;
    logic [XLEN-1:0] mplier_sel;
    logic [XLEN-1:0] acc_next;
    logic            unused_ir;

    assign opc        = ir_i[OPC_HI:OPC_LO];
    assign unused_ir  = ^ir_i[RD_LO-1:IMM_HI+1];
    assign mplier_sel = (opc == ALU_MULI) ?
                        {{(XLEN-IMM_W){ir_i[IMM_HI]}}, ir_i[IMM_HI:IMM_LO]} : rt_val_i;

    // rst_ni gates acceptance so stall_o is low throughout reset even with a MUL on ir_i.
    assign accept     = (state_q == IDLE) && valid_i && is_mul_op(opc) && !flush_i && rst_ni;
    assign step       = (state_q == RUN) && !flush_i;
    assign count_next = count_q + 1'b1;
    assign run_exit   = (count_next == CW'(STEPS)) || ((EARLY_END != 0) && mplier_zero);

    assign stall_o        = accept || step;
    assign busy_o         = (state_q == RUN);
    assign result_valid_o = (state_q == DONE) && !flush_i;
    assign dbg_state_o    = state_q;

    mul_shift_add_dp #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_dp (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .load_i        (accept),
        .step_i        (step),
        .mcand_i       (rs_val_i),
        .mplier_i      (mplier_sel),
        .acc_next_o    (acc_next),
        .mplier_zero_o (mplier_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_q     <= '0;
            result_o <= '0;
            wb_rd_o  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RUN;
                        count_q <= '0;
                        rd_q    <= ir_i[RD_HI:RD_LO];
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        count_q <= count_next;
                        // Result registers capture the final sum and hold it until the next completion.
                        if (run_exit) begin
                            state_q  <= DONE;
                            result_o <= acc_next;
                            wb_rd_o  <= rd_q;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
